toggle_watchdog: RTL and testbench

Downstream monitor for the toggle flop output. It synchronises the toggle stream into `clk`, detects every transition, and measures the half-period in `clk` cycles. It declares lock after a run of in-window half-periods. It raises a sticky fault when the toggle runs too fast or stops. It feeds the status/interrupt logic that checks divider-chain health.

---
 rtl/toggle_watchdog.sv | 137 +++++++++++++
 tb/tb_toggle_watchdog.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/toggle_watchdog.sv
// rtl/toggle_watchdog.sv - toggle stream monitor: half-period measurement, lock and sticky fault
module toggle_watchdog #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HALF    = 2,
    parameter int MAX_HALF    = 1000,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    input  logic             toggle_in,
    input  logic             fault_clr,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             half_period_valid,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam int GW = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_HALF);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_HALF);
    localparam logic [GW-1:0]    LOCK_C = GW'(LOCK_COUNT);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_LOCKED  = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_FAST  = 2'b01;
    localparam logic [1:0] CODE_STUCK = 2'b10;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   p_q;
    logic                   s;
    logic                   edge_det;
    logic [2:0]             state, state_d;
    logic [CNT_W-1:0]       cnt;
    logic [GW-1:0]          good_cnt, good_d;
    logic [1:0]             code_d;
    logic                   active, measuring, in_win, fast, stuck;

    assign s        = sync_q[SYNC_STAGES-1];
    assign edge_det = s ^ p_q;

    assign active    = (state == S_ARMED) || (state == S_MEASURE) || (state == S_LOCKED);
    assign measuring = (state == S_MEASURE) || (state == S_LOCKED);
    assign in_win    = (cnt >= MIN_C) && (cnt <= MAX_C);
    assign fast      = measuring && edge_det && (cnt < MIN_C);
    // cnt is about to reach MAX_HALF+1 without an edge
    assign stuck     = active && !edge_det && (cnt == MAX_C);

    assign locked = (state == S_LOCKED);
    assign fault  = (state == S_FAULT);

    always_comb begin
        state_d = state;
        good_d  = good_cnt;
        code_d  = fault_code;
        case (state)
            S_IDLE: begin
                good_d = '0;
                if (en) state_d = S_ARMED;
            end
            S_FAULT: begin
                if (fault_clr) begin
                    state_d = S_IDLE;
                    code_d  = CODE_NONE;
                    good_d  = '0;
                end
            end
            default: begin
                if (!en) begin
                    state_d = S_IDLE;
                    good_d  = '0;
                end else if (fast || stuck) begin
                    good_d = '0;
                    if (fault_clr) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FAULT;
                        code_d  = fast ? CODE_FAST : CODE_STUCK;
                    end
                end else if (edge_det) begin
                    if (state == S_ARMED) begin
                        state_d = S_MEASURE;
                        good_d  = '0;
                    end else if (state == S_MEASURE) begin
                        if (in_win) begin
                            good_d = good_cnt + GW'(1);
                            if (good_cnt + GW'(1) == LOCK_C) state_d = S_LOCKED;
                        end else begin
                            good_d = '0;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync_q            <= '0;
            p_q               <= 1'b0;
            state             <= S_IDLE;
            cnt               <= '0;
            good_cnt          <= '0;
            fault_code        <= CODE_NONE;
            edge_pulse        <= 1'b0;
            half_period       <= '0;
            half_period_valid <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], toggle_in};
            p_q        <= s;
            state      <= state_d;
            good_cnt   <= good_d;
            fault_code <= code_d;
            edge_pulse <= edge_det && en && (state != S_FAULT);

            if (state == S_IDLE) begin
                cnt <= '0;
            end else if (state != S_FAULT) begin
                if (edge_det)        cnt <= CNT_W'(1);
                else if (cnt != '1)  cnt <= cnt + CNT_W'(1);
            end

            half_period_valid <= edge_det && measuring;
            if (edge_det && measuring) half_period <= cnt;
        end
    end

endmodule

// File: tb/tb_toggle_watchdog.sv
// tb/tb_toggle_watchdog.sv - directed vector bench for toggle_watchdog
module tb_toggle_watchdog;

    logic        clk = 1'b0;
    logic        clear_n, en, toggle_in, fault_clr;
    logic        edge_pulse, half_period_valid, locked, fault;
    logic [15:0] half_period;
    logic [1:0]  fault_code;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        en;
        logic        tog;
        logic        clr;
        logic        ep;
        logic        hpv;
        logic [15:0] hp;
        logic        lk;
        logic        flt;
        logic [1:0]  code;
    } vec_t;

    vec_t        tbl[27];
    logic [15:0] hp_q[$];
    int          ep_seen;

    always #5 clk = ~clk;

    toggle_watchdog #(
        .CNT_W(16), .SYNC_STAGES(2), .MIN_HALF(2), .MAX_HALF(10), .LOCK_COUNT(4)
    ) dut (
        .clk(clk), .clear_n(clear_n), .en(en), .toggle_in(toggle_in), .fault_clr(fault_clr),
        .edge_pulse(edge_pulse), .half_period(half_period), .half_period_valid(half_period_valid),
        .locked(locked), .fault(fault), .fault_code(fault_code)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic half(input int n);
        toggle_in = ~toggle_in;
        repeat (n) begin
            tick();
            if (half_period_valid) hp_q.push_back(half_period);
            if (edge_pulse) ep_seen++;
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ep"},   32'(edge_pulse), 0);
        check({name, "_hp"},   32'(half_period), 0);
        check({name, "_hpv"},  32'(half_period_valid), 0);
        check({name, "_lk"},   32'(locked), 0);
        check({name, "_flt"},  32'(fault), 0);
        check({name, "_code"}, 32'(fault_code), 0);
    endtask

    initial begin
        int got;

        // Lock sequence: toggle flips every 4 cycles; edges seen as edge_pulse at steps 6,10,...
        for (int k = 0; k < 27; k++) begin
            tbl[k].en   = 1'b1;
            tbl[k].tog  = k[2];
            tbl[k].clr  = 1'b0;
            tbl[k].ep   = (k >= 6) && ((k - 6) % 4 == 0);
            tbl[k].hpv  = (k >= 10) && ((k - 10) % 4 == 0);
            tbl[k].hp   = (k >= 10) ? 16'd4 : 16'd0;
            tbl[k].lk   = (k >= 22);
            tbl[k].flt  = 1'b0;
            tbl[k].code = 2'b00;
        end

        clear_n = 1'b0; en = 1'b0; toggle_in = 1'b0; fault_clr = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        clear_n = 1'b1;

        for (int k = 0; k < 27; k++) begin
            en = tbl[k].en; toggle_in = tbl[k].tog; fault_clr = tbl[k].clr;
            tick();
            check($sformatf("lock_ep[%0d]", k),   32'(edge_pulse),        32'(tbl[k].ep));
            check($sformatf("lock_hpv[%0d]", k),  32'(half_period_valid), 32'(tbl[k].hpv));
            check($sformatf("lock_hp[%0d]", k),   32'(half_period),       32'(tbl[k].hp));
            check($sformatf("lock_lk[%0d]", k),   32'(locked),            32'(tbl[k].lk));
            check($sformatf("lock_flt[%0d]", k),  32'(fault),             32'(tbl[k].flt));
            check($sformatf("lock_code[%0d]", k), 32'(fault_code),        32'(tbl[k].code));
        end

        // STUCK: last edge_pulse at step 26, fault exactly 10 cycles later
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("stuck_pre_flt[%0d]", i), 32'(fault), 0);
            check($sformatf("stuck_pre_lk[%0d]", i), 32'(locked), 1);
        end
        tick();
        check("stuck_flt", 32'(fault), 1);
        check("stuck_code", 32'(fault_code), 2);
        check("stuck_lk", 32'(locked), 0);
        check("stuck_hp_kept", 32'(half_period), 4);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("stuck_clr_flt", 32'(fault), 0);
        check("stuck_clr_code", 32'(fault_code), 0);
        tick();

        // Boundary half-periods 2 and 10 both count toward lock
        hp_q.delete();
        half(2); half(10); half(2); half(10);
        check("bound_not_locked", 32'(locked), 0);
        half(3);
        check("bound_count", 32'(hp_q.size()), 4);
        if (hp_q.size() == 4) begin
            check("bound_hp0", 32'(hp_q[0]), 2);
            check("bound_hp1", 32'(hp_q[1]), 10);
            check("bound_hp2", 32'(hp_q[2]), 2);
            check("bound_hp3", 32'(hp_q[3]), 10);
        end
        check("bound_locked", 32'(locked), 1);
        check("bound_flt", 32'(fault), 0);

        // Disable while locked, then re-enable without a toggle change
        en = 1'b0;
        tick();
        check("dis_lk", 32'(locked), 0);
        repeat (3) tick();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("reen_ep[%0d]", i), 32'(edge_pulse), 0);
        end

        // FAST: flip every cycle from ARMED
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            toggle_in = ~toggle_in;
            tick();
            if (half_period_valid) begin
                got = 1;
                check("fast_hp", 32'(half_period), 1);
            end
        end
        check("fast_measured", 32'(got), 1);
        toggle_in = ~toggle_in;
        tick();
        check("fast_flt", 32'(fault), 1);
        check("fast_code", 32'(fault_code), 1);
        check("fast_lk", 32'(locked), 0);
        for (int i = 0; i < 5; i++) begin
            toggle_in = ~toggle_in;
            tick();
            check($sformatf("fast_no_ep[%0d]", i), 32'(edge_pulse), 0);
        end
        repeat (3) tick();
        check("fast_code_held", 32'(fault_code), 1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("fast_clr_flt", 32'(fault), 0);
        tick();

        // fault_clr coincident with the STUCK trigger: clear wins
        toggle_in = ~toggle_in;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            tick();
            if (edge_pulse) got = 1;
        end
        check("prio_edge_seen", 32'(got), 1);
        repeat (9) tick();
        check("prio_pre_flt", 32'(fault), 0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("prio_flt", 32'(fault), 0);
        check("prio_code", 32'(fault_code), 0);
        repeat (2) tick();
        check("prio_flt_after", 32'(fault), 0);

        // Async reset mid-lock, then relock needs 5 edges
        repeat (5) half(4);
        check("pre_rst_locked", 32'(locked), 1);
        #3;
        clear_n = 1'b0;
        toggle_in = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (2) tick();
        clear_n = 1'b1;
        repeat (4) half(4);
        check("relock_4_edges", 32'(locked), 0);
        half(4);
        check("relock_5_edges", 32'(locked), 1);
        check("relock_hp", 32'(half_period), 4);
        check("relock_flt", 32'(fault), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
